rwf_loop_controller: RTL
========================

Name: rwf_loop_controller

Overview:
- Acquisition/tracking sequencer for the ADPLL random-walk loop filter.
- Monitors the filter's Positive/Negative shift pulses over fixed observation windows and decides acquisition versus tracking.
- Drives the filter threshold magnitude: small for fast acquisition, large for low-jitter tracking.
- Issues a filter clear on every mode change and reports the lock status to the system.

Parameters:
WindowLen, 256, observation window length in MainClock cycles (>=2)
WinCntWidth, 16, window counter width; must hold WindowLen-1
AcqThreshold, 2, filter threshold magnitude in ACQUIRE (1..127)
TrkThreshold, 8, filter threshold magnitude in TRACK (1..127)
LockTol, 1, max |net| per window counted as a good window
UnlockTol, 4, |net| above this in TRACK causes loss of lock
LockWindows, 4, consecutive good windows required to lock (1..15)

Ports:
MainClock  in  1  system clock, all logic on rising edge
ResetN  in  1  asynchronous active-low reset
Enable  in  1  loop run request, level-sensitive
Positive  in  1  filter positive-shift pulse, 1 cycle
Negative  in  1  filter negative-shift pulse, 1 cycle
FilterThreshold  out  8  threshold magnitude for the filter; the filter uses +T and 256-T
FilterClear  out  1  one-cycle pulse that clears the filter counter
Locked  out  1  high while in TRACK
LoopState  out  2  00 IDLE, 01 ACQUIRE, 10 TRACK
WindowDone  out  1  one-cycle pulse when a window evaluation completes

Behaviour:
- Reset (ResetN=0, async): LoopState=IDLE. FilterThreshold=AcqThreshold. FilterClear=0, Locked=0, WindowDone=0. All counters are 0.
- All outputs are registered.
- Counters:
  - WinCnt counts 0..WindowLen-1, then wraps to 0.
  - PosCnt and NegCnt are 8-bit, saturate at 255, and increment on Positive/Negative respectively.
  - Positive and Negative high in the same cycle: both counters increment.
- Window end is the cycle with WinCnt==WindowLen-1.
  - Pulses in that cycle are included in the evaluation.
  - net = PosCnt-NegCnt as a 9-bit signed value; |net| is computed on the final counts.
  - Next cycle: WindowDone=1; WinCnt, PosCnt and NegCnt restart from 0.
  - A pulse arriving in that next cycle counts toward the new window.
- GoodCnt is a 4-bit counter of consecutive good windows (|net|<=LockTol). A bad window clears it to 0.
- IDLE:
  - Counters are held at 0; FilterThreshold=AcqThreshold.
  - When Enable=1 is sampled: next cycle LoopState=ACQUIRE and FilterClear=1 for one cycle. The window starts at WinCnt=0 in that cycle.
- ACQUIRE:
  - FilterThreshold=AcqThreshold.
  - At window end, GoodCnt is updated.
  - If GoodCnt reaches LockWindows: next cycle LoopState=TRACK, Locked=1, FilterThreshold=TrkThreshold, FilterClear=1; GoodCnt is cleared.
- TRACK:
  - At window end, if |net|>UnlockTol: next cycle LoopState=ACQUIRE, Locked=0, FilterThreshold=AcqThreshold, FilterClear=1; GoodCnt=0.
  - Otherwise the controller stays in TRACK.
- In every state change, the FilterThreshold update and the FilterClear pulse occur in the same cycle. WindowDone also pulses on that cycle.
- Enable=0 sampled in any state:
  - Next cycle: IDLE, Locked=0, FilterThreshold=AcqThreshold, counters cleared.
  - No FilterClear on entry to IDLE.
  - This takes priority over a window-end evaluation in the same cycle.
- Async reset mid-window: immediate return to reset values. No partial evaluation and no FilterClear.
- Saturated PosCnt or NegCnt: evaluation uses the saturated values. Both saturated gives net=0, which counts as a good window.

Test Plan:
- Reset, then Enable=1, no pulses, WindowLen=16, LockWindows=4:
  - FilterClear pulses in cycle 1.
  - WindowDone pulses every 16 cycles.
  - After the 4th window: LoopState=10, Locked=1, FilterThreshold=8, FilterClear pulse.
- In ACQUIRE, 3 Positive in window 2, after 1 good window:
  - GoodCnt resets.
  - Lock occurs only after 4 further consecutive good windows.
- In TRACK, 5 Positive and 0 Negative in one window:
  - Next cycle after window end: LoopState=01, Locked=0, FilterThreshold=2, FilterClear=1.
- In TRACK, 4 Positive and 0 Negative in one window: stays TRACK (4 is not >UnlockTol).
- Positive and Negative high together for 10 cycles: PosCnt=NegCnt=10, net=0, good window.
- Pulse on the window-end cycle: it is counted in that window.
- Pulse one cycle after window end: it is counted in the next window.
- Enable dropped and ResetN asserted mid-window in TRACK:
  - Enable dropped: next cycle LoopState=00, Locked=0, FilterThreshold=2, no FilterClear.
  - ResetN asserted: outputs reset asynchronously, with no clock edge required.

Source files
------------

// File: rtl/rwf_loop_controller.sv
// Acquisition/tracking sequencer for an ADPLL random-walk loop filter.
// Watches filter shift pulses per window and switches the filter threshold between acquire and track.
module rwf_loop_controller #(
  parameter int WindowLen    = 256,
  parameter int WinCntWidth  = 16,
  parameter int AcqThreshold = 2,
  parameter int TrkThreshold = 8,
  parameter int LockTol      = 1,
  parameter int UnlockTol    = 4,
  parameter int LockWindows  = 4
) (
  input  logic       MainClock,
  input  logic       ResetN,
  input  logic       Enable,
  input  logic       Positive,
  input  logic       Negative,
  output logic [7:0] FilterThreshold,
  output logic       FilterClear,
  output logic       Locked,
  output logic [1:0] LoopState,
  output logic       WindowDone
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ACQUIRE = 2'b01,
    ST_TRACK   = 2'b10
  } state_t;

  localparam logic [WinCntWidth-1:0] WinLast = WinCntWidth'(WindowLen - 1);
  localparam logic [WinCntWidth-1:0] WinOne  = WinCntWidth'(1);
  localparam logic [7:0]             AcqThr  = 8'(AcqThreshold);
  localparam logic [7:0]             TrkThr  = 8'(TrkThreshold);
  localparam logic [8:0]             LockTolV   = 9'(LockTol);
  localparam logic [8:0]             UnlockTolV = 9'(UnlockTol);
  localparam logic [3:0]             LockWinV   = 4'(LockWindows);

  state_t                 r_state;
  logic [WinCntWidth-1:0] r_win_cnt;
  logic [7:0]             r_pos_cnt;
  logic [7:0]             r_neg_cnt;
  logic [3:0]             r_good_cnt;
  logic [7:0]             r_threshold;
  logic                   r_clear;
  logic                   r_locked;
  logic                   r_win_done;

  state_t                 w_state_next;
  logic [WinCntWidth-1:0] w_win_cnt_next;
  logic [7:0]             w_pos_cnt_next;
  logic [7:0]             w_neg_cnt_next;
  logic [3:0]             w_good_cnt_next;
  logic [7:0]             w_threshold_next;
  logic                   w_clear_next;
  logic                   w_locked_next;
  logic                   w_win_done_next;

  logic [7:0] w_pos_final;
  logic [7:0] w_neg_final;
  logic [8:0] w_net;
  logic [8:0] w_abs_net;
  logic       w_win_end;
  logic       w_good;
  logic [3:0] w_good_inc;

  // Final counts include a pulse arriving on the current cycle, saturating at 255.
  assign w_pos_final = (Positive && (r_pos_cnt != 8'hFF)) ? (r_pos_cnt + 8'd1) : r_pos_cnt;
  assign w_neg_final = (Negative && (r_neg_cnt != 8'hFF)) ? (r_neg_cnt + 8'd1) : r_neg_cnt;
  assign w_net       = {1'b0, w_pos_final} - {1'b0, w_neg_final};
  assign w_abs_net   = w_net[8] ? (9'd0 - w_net) : w_net;
  assign w_win_end   = (r_win_cnt == WinLast);
  assign w_good      = (w_abs_net <= LockTolV);
  assign w_good_inc  = (r_good_cnt == 4'hF) ? 4'hF : (r_good_cnt + 4'd1);

  always_ff @(posedge MainClock or negedge ResetN) begin
    if (!ResetN) begin
      r_state     <= ST_IDLE;
      r_win_cnt   <= '0;
      r_pos_cnt   <= 8'd0;
      r_neg_cnt   <= 8'd0;
      r_good_cnt  <= 4'd0;
      r_threshold <= AcqThr;
      r_clear     <= 1'b0;
      r_locked    <= 1'b0;
      r_win_done  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_win_cnt   <= w_win_cnt_next;
      r_pos_cnt   <= w_pos_cnt_next;
      r_neg_cnt   <= w_neg_cnt_next;
      r_good_cnt  <= w_good_cnt_next;
      r_threshold <= w_threshold_next;
      r_clear     <= w_clear_next;
      r_locked    <= w_locked_next;
      r_win_done  <= w_win_done_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_win_cnt_next   = r_win_cnt;
    w_pos_cnt_next   = r_pos_cnt;
    w_neg_cnt_next   = r_neg_cnt;
    w_good_cnt_next  = r_good_cnt;
    w_threshold_next = r_threshold;
    w_clear_next     = 1'b0;
    w_locked_next    = r_locked;
    w_win_done_next  = 1'b0;

    if (!Enable) begin
      // Dropping Enable wins over any window evaluation and does not clear the filter.
      w_state_next     = ST_IDLE;
      w_win_cnt_next   = '0;
      w_pos_cnt_next   = 8'd0;
      w_neg_cnt_next   = 8'd0;
      w_good_cnt_next  = 4'd0;
      w_threshold_next = AcqThr;
      w_locked_next    = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_next     = ST_ACQUIRE;
          w_clear_next     = 1'b1;
          w_win_cnt_next   = '0;
          w_pos_cnt_next   = 8'd0;
          w_neg_cnt_next   = 8'd0;
          w_good_cnt_next  = 4'd0;
          w_threshold_next = AcqThr;
          w_locked_next    = 1'b0;
        end

        ST_ACQUIRE, ST_TRACK: begin
          if (w_win_end) begin
            w_win_cnt_next  = '0;
            w_pos_cnt_next  = 8'd0;
            w_neg_cnt_next  = 8'd0;
            w_win_done_next = 1'b1;
            if (r_state == ST_ACQUIRE) begin
              if (!w_good) begin
                w_good_cnt_next = 4'd0;
              end else if (w_good_inc >= LockWinV) begin
                w_state_next     = ST_TRACK;
                w_good_cnt_next  = 4'd0;
                w_threshold_next = TrkThr;
                w_locked_next    = 1'b1;
                w_clear_next     = 1'b1;
              end else begin
                w_good_cnt_next = w_good_inc;
              end
            end else if (w_abs_net > UnlockTolV) begin
              w_state_next     = ST_ACQUIRE;
              w_good_cnt_next  = 4'd0;
              w_threshold_next = AcqThr;
              w_locked_next    = 1'b0;
              w_clear_next     = 1'b1;
            end
          end else begin
            w_win_cnt_next = r_win_cnt + WinOne;
            w_pos_cnt_next = w_pos_final;
            w_neg_cnt_next = w_neg_final;
          end
        end

        default: begin
          w_state_next     = ST_IDLE;
          w_win_cnt_next   = '0;
          w_pos_cnt_next   = 8'd0;
          w_neg_cnt_next   = 8'd0;
          w_good_cnt_next  = 4'd0;
          w_threshold_next = AcqThr;
          w_locked_next    = 1'b0;
        end
      endcase
    end
  end

  assign FilterThreshold = r_threshold;
  assign FilterClear     = r_clear;
  assign Locked          = r_locked;
  assign LoopState       = r_state;
  assign WindowDone      = r_win_done;

endmodule
